// File: rtl/key_led_pkg.sv
// Shared types, widths and the parameter range check for key_led_driver.
// Optional blink mode of the driver is enabled by defining KEY_LED_BLINK_EN.
package key_led_pkg;

   typedef enum logic {
      IDLE   = 1'b0,
      ACTIVE = 1'b1
   } chan_state_e;

   localparam int HOLD_W  = 8;
   localparam int PRESC_W = 20;

   function automatic bit params_ok(input int tick, input int hold);
      return (tick >= 2) && (tick <= (1 << PRESC_W)) &&
             (hold >= 1) && (hold <= (1 << HOLD_W) - 1);
   endfunction

endpackage

// File: rtl/key_led_cell.sv
// One indicator channel: retriggerable hold FSM with an optional blink phase.
// Blink phase logic exists only when KEY_LED_BLINK_EN is defined.
module key_led_cell
   import key_led_pkg::*;
#(
   parameter int HOLD = 50
) (
   input  logic clk,
   input  logic rstn,
   input  logic pulse_i,
   input  logic tick,
   output logic led_o,
   output logic active_o
);

   localparam logic [HOLD_W-1:0] HOLD_V = HOLD_W'(HOLD);

   chan_state_e       r_state;
   chan_state_e       w_state_nxt;
   logic [HOLD_W-1:0] r_hold;
   logic [HOLD_W-1:0] w_hold_nxt;

   // A pulse always reloads, even on the tick that would expire the channel.
   always_comb begin
      w_state_nxt = r_state;
      w_hold_nxt  = r_hold;
      if (pulse_i) begin
         w_state_nxt = ACTIVE;
         w_hold_nxt  = HOLD_V;
      end else if ((r_state == ACTIVE) && tick) begin
         if (r_hold == HOLD_W'(1)) begin
            w_state_nxt = IDLE;
            w_hold_nxt  = '0;
         end else begin
            w_hold_nxt = r_hold - HOLD_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state <= IDLE;
         r_hold  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_hold  <= w_hold_nxt;
      end
   end

   // Next-state flag, so the top-level busy register lines up with led.
   assign active_o = (w_state_nxt == ACTIVE);

`ifdef KEY_LED_BLINK_EN
   logic r_phase;
   logic w_phase_nxt;

   always_comb begin
      w_phase_nxt = r_phase;
      if (pulse_i) begin
         w_phase_nxt = 1'b1;
      end else if (w_state_nxt == IDLE) begin
         w_phase_nxt = 1'b0;
      end else if (tick) begin
         w_phase_nxt = ~r_phase;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_phase <= 1'b0;
      end else begin
         r_phase <= w_phase_nxt;
      end
   end

   assign led_o = (r_state == ACTIVE) & r_phase;
`else
   assign led_o = (r_state == ACTIVE);
`endif

endmodule

// File: rtl/key_led_driver.sv
// Timed LED/buzzer driver: shared tick prescaler plus BIT+1 hold channels.
// Define KEY_LED_BLINK_EN to make active channels blink with a 2-tick period.
module key_led_driver
   import key_led_pkg::*;
#(
   parameter int BIT  = 5,
   parameter int TICK = 1000000,
   parameter int HOLD = 50
) (
   input  logic         clk,
   input  logic         rstn,
   input  logic [BIT:0] pulse,
   output logic [BIT:0] led,
   output logic         busy,
   output logic         tick
);

   localparam logic [PRESC_W-1:0] TICK_LAST = PRESC_W'(TICK - 1);

   if (!params_ok(TICK, HOLD)) begin : g_bad_params
      $error("key_led_driver: TICK or HOLD out of range");
   end

   logic [PRESC_W-1:0] r_presc;
   logic               r_tick;
   logic               r_busy;
   logic [BIT:0]       w_active;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_presc <= '0;
         r_tick  <= 1'b0;
         r_busy  <= 1'b0;
      end else begin
         r_tick  <= (r_presc == TICK_LAST);
         r_presc <= (r_presc == TICK_LAST) ? '0 : r_presc + 1'b1;
         r_busy  <= |w_active;
      end
   end

   for (genvar gi = 0; gi <= BIT; gi++) begin : g_cell
      key_led_cell #(
         .HOLD(HOLD)
      ) u_cell (
         .clk     (clk),
         .rstn    (rstn),
         .pulse_i (pulse[gi]),
         .tick    (r_tick),
         .led_o   (led[gi]),
         .active_o(w_active[gi])
      );
   end

   assign tick = r_tick;
   assign busy = r_busy;

endmodule
